bfly_router: RTL and testbench

BFLY_ROUTER -- requirements
Module: bfly_router

---
 rtl/bfly_pkg.sv | 36 +++
 rtl/bfly_fifo.sv | 62 ++++++
 rtl/bfly_router.sv | 123 ++++++++++++
 tb/tb_bfly_router.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bfly_pkg.sv
// Shared defaults and route-field helpers for the butterfly router slice.
// Helpers work on a wide zero-extended phit so any parameterisation can reuse them.
package bfly_pkg;

    localparam int BFLY_N_PORTS    = 4;
    localparam int BFLY_PHIT_W     = 18;
    localparam int BFLY_ROUTE_W    = 6;
    localparam int BFLY_FIFO_DEPTH = 4;
    localparam int MAX_PHIT_W      = 128;

    typedef logic [MAX_PHIT_W-1:0] wide_phit_t;

    // Destination of the current hop: the top hopW bits of the phit.
    function automatic int unsigned route_dest(input wide_phit_t phit,
                                               input int         phitW,
                                               input int         hopW);
        wide_phit_t shifted;
        shifted = phit >> (phitW - hopW);
        return 32'(shifted);
    endfunction

    // Shift the route field up by one hop (zero fill), leaving the payload intact.
    function automatic wide_phit_t consume_hop(input wide_phit_t phit,
                                               input int         phitW,
                                               input int         routeW,
                                               input int         hopW);
        wide_phit_t mask;
        wide_phit_t route;
        int         base;
        base  = phitW - routeW;
        mask  = (wide_phit_t'(1) << routeW) - wide_phit_t'(1);
        route = ((phit >> base) << hopW) & mask;
        return (phit & ~(mask << base)) | (route << base);
    endfunction

endpackage

// File: rtl/bfly_fifo.sv
// Per-input phit FIFO. A freshly pushed entry is hidden from the arbiters for
// one cycle, so o_empty reflects only entries that were already present.
module bfly_fifo #(
    parameter int PHIT_W     = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [PHIT_W-1:0] i_data,
    input  logic              i_pop,
    output logic [PHIT_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [PHIT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic              r_pushLast;
    logic              w_doPush;
    logic              w_doPop;

    assign o_full   = (r_count == CW'(FIFO_DEPTH));
    assign o_empty  = (r_count == CW'(r_pushLast));
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_head   = r_mem[r_rdPtr];

    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_pushLast <= 1'b0;
        end else begin
            r_pushLast <= w_doPush;
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bfly_router.sv
// Butterfly router stage: per-input FIFOs feeding per-output round-robin
// arbiters and registered outputs; each loaded phit has one route hop consumed.
module bfly_router
    import bfly_pkg::*;
#(
    parameter int N_PORTS    = BFLY_N_PORTS,
    parameter int PHIT_W     = BFLY_PHIT_W,
    parameter int ROUTE_W    = BFLY_ROUTE_W,
    parameter int FIFO_DEPTH = BFLY_FIFO_DEPTH
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [N_PORTS-1:0][PHIT_W-1:0] i_inputs,
    input  logic [N_PORTS-1:0]             i_valid,
    output logic [N_PORTS-1:0]             o_ready,
    output logic [N_PORTS-1:0][PHIT_W-1:0] o_outputs,
    output logic [N_PORTS-1:0]             o_valid,
    input  logic [N_PORTS-1:0]             i_ready
);
    localparam int LOG2N = $clog2(N_PORTS);

    logic               r_rdyEn;
    logic [N_PORTS-1:0] w_full;
    logic [N_PORTS-1:0] w_empty;
    logic [N_PORTS-1:0] w_pop;
    logic [PHIT_W-1:0]  w_head  [N_PORTS];
    logic [LOG2N-1:0]   w_dest  [N_PORTS];
    logic [N_PORTS-1:0] w_grant [N_PORTS];

    // Holds o_ready low through reset and until the first edge after release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdyEn <= 1'b0;
        end else begin
            r_rdyEn <= 1'b1;
        end
    end

    assign o_ready = {N_PORTS{r_rdyEn}} & ~w_full;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_in
        bfly_fifo #(
            .PHIT_W    (PHIT_W),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_push (i_valid[i] & o_ready[i]),
            .i_data (i_inputs[i]),
            .i_pop  (w_pop[i]),
            .o_head (w_head[i]),
            .o_full (w_full[i]),
            .o_empty(w_empty[i])
        );

        assign w_dest[i] = LOG2N'(route_dest(MAX_PHIT_W'(w_head[i]), PHIT_W, LOG2N));
    end

    // A head targets exactly one output, so at most one grant per input is set.
    always_comb begin
        w_pop = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            w_pop = w_pop | w_grant[j];
        end
    end

    for (genvar j = 0; j < N_PORTS; j++) begin : g_out
        logic [N_PORTS-1:0] w_req;
        logic [LOG2N-1:0]   r_prio;
        logic [LOG2N-1:0]   w_sel;
        logic [LOG2N-1:0]   w_idx;
        logic               w_found;
        logic               w_load;
        logic [PHIT_W-1:0]  w_next;
        logic [PHIT_W-1:0]  r_data;
        logic               r_valid;

        always_comb begin
            w_req = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                w_req[i] = !w_empty[i] && (w_dest[i] == LOG2N'(j));
            end
        end

        assign w_load = !r_valid || i_ready[j];

        // Scan requesters starting at r_prio, wrapping past the top index.
        always_comb begin
            w_found = 1'b0;
            w_sel   = '0;
            w_idx   = '0;
            for (int k = 0; k < N_PORTS; k++) begin
                w_idx = r_prio + LOG2N'(k);
                if (!w_found && w_req[w_idx]) begin
                    w_found = 1'b1;
                    w_sel   = w_idx;
                end
            end
        end

        assign w_grant[j] = (w_found && w_load) ? (N_PORTS'(1) << w_sel) : '0;
        assign w_next     = PHIT_W'(consume_hop(MAX_PHIT_W'(w_head[w_sel]),
                                                PHIT_W, ROUTE_W, LOG2N));

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_data  <= '0;
                r_valid <= 1'b0;
                r_prio  <= '0;
            end else if (w_found && w_load) begin
                r_data  <= w_next;
                r_valid <= 1'b1;
                r_prio  <= w_sel + LOG2N'(1);
            end else if (i_ready[j]) begin
                r_valid <= 1'b0;
            end
        end

        assign o_outputs[j] = r_data;
        assign o_valid[j]   = r_valid;
    end

endmodule

// File: tb/tb_bfly_router.sv
// Self-checking bench for bfly_router: a negedge monitor queues expected phits
// per output on acceptance and compares them as the outputs are consumed.
module tb_bfly_router;

    logic              clock = 1'b0;
    logic              reset;
    logic [3:0][17:0]  inputs;
    logic [3:0]        valid;
    logic [3:0]        oReady;
    logic [3:0][17:0]  outputs;
    logic [3:0]        oValid;
    logic [3:0]        iReady;

    int checks    = 0;
    int errors    = 0;
    int cycle     = 0;
    int spurious  = 0;
    int pushStart = 0;
    int delivered [4];
    int firstCyc  [4];
    int lastCyc   [4];
    bit monEn     = 1'b0;
    logic [17:0] expQ [4][$];

    always #5 clock = ~clock;

    bfly_router #(
        .N_PORTS   (4),
        .PHIT_W    (18),
        .ROUTE_W   (6),
        .FIFO_DEPTH(4)
    ) dut (
        .i_clk    (clock),
        .i_rst    (reset),
        .i_inputs (inputs),
        .i_valid  (valid),
        .o_ready  (oReady),
        .o_outputs(outputs),
        .o_valid  (oValid),
        .i_ready  (iReady)
    );

    // Expected effect of one hop: route bits move up two places, payload kept.
    function automatic logic [17:0] hopModel(input logic [17:0] p);
        return {p[15:12], 2'b00, p[11:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // Presents a pattern for exactly one clock edge.
    task automatic applyStimulus(input logic [3:0] v, input logic [3:0][17:0] d);
        valid  = v;
        inputs = d;
        waitCycles(1);
        valid  = '0;
    endtask

    task automatic clearCounters();
        for (int j = 0; j < 4; j++) begin
            delivered[j] = 0;
            firstCyc[j]  = 0;
            lastCyc[j]   = 0;
        end
        spurious = 0;
    endtask

    task automatic checkDrained();
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("drain%0d", j), 32'(expQ[j].size()), 32'd0);
        end
    endtask

    always @(posedge clock) cycle++;

    // Scoreboard: push on accepted input, pop and compare on consumed output.
    always @(negedge clock) begin
        if (monEn && !reset) begin
            for (int n = 0; n < 4; n++) begin
                int i;
                i = (n + pushStart) % 4;
                if (valid[i] && oReady[i]) begin
                    expQ[inputs[i][17:16]].push_back(hopModel(inputs[i]));
                end
            end
            for (int j = 0; j < 4; j++) begin
                if (oValid[j] && iReady[j]) begin
                    if (expQ[j].size() == 0) begin
                        spurious++;
                    end else begin
                        logic [17:0] e;
                        e = expQ[j].pop_front();
                        checkOutput($sformatf("out%0d", j), 32'(outputs[j]), 32'(e));
                    end
                    delivered[j]++;
                    if (delivered[j] == 1) firstCyc[j] = cycle;
                    lastCyc[j] = cycle;
                end
            end
        end
    end

    initial begin
        logic [3:0][17:0] d;
        logic [17:0]      ph [6];
        int               acc;
        int               stalls;

        reset  = 1'b1;
        valid  = '0;
        inputs = '0;
        iReady = '1;
        #2;
        checkOutput("rstValid", 32'(oValid), 32'd0);
        checkOutput("rstReady", 32'(oReady), 32'd0);
        checkOutput("rstData", 32'(|outputs), 32'd0);
        #20 reset = 1'b0;
        #1;
        checkOutput("relReady0", 32'(oReady), 32'd0);
        @(posedge clock);
        #2;
        checkOutput("relReady1", 32'(oReady), 32'hF);
        monEn = 1'b1;

        // Basic route with minimum latency.
        clearCounters();
        d = '0;
        d[0] = 18'h27ABC;
        applyStimulus(4'b0001, d);
        waitCycles(1);
        checkOutput("lat1Valid", 32'(oValid), 32'd0);
        waitCycles(1);
        checkOutput("lat2Valid", 32'(oValid), 32'h4);
        checkOutput("basicData", 32'(outputs[2]), 32'h1CABC);
        waitCycles(4);
        checkOutput("basicCnt", 32'(delivered[2]), 32'd1);
        checkDrained();

        // Contention on output 1, twice, each burst from input 0 upward.
        for (int b = 0; b < 2; b++) begin
            clearCounters();
            for (int i = 0; i < 4; i++) d[i] = {2'b01, 4'(i + 3 + b), 12'(12'hA00 + 16 * b + i)};
            applyStimulus(4'b1111, d);
            waitCycles(8);
            checkOutput($sformatf("contCnt%0d", b), 32'(delivered[1]), 32'd4);
            checkOutput($sformatf("contSpan%0d", b), 32'(lastCyc[1] - firstCyc[1]), 32'd3);
        end
        checkDrained();

        // Round-robin pointer resumes after the last grant (input 2 -> 3 first).
        d = '0;
        d[2] = {2'b01, 4'h9, 12'h222};
        applyStimulus(4'b0100, d);
        waitCycles(5);
        pushStart = 3;
        d = '0;
        d[0] = {2'b01, 4'h1, 12'h300};
        d[3] = {2'b01, 4'h2, 12'h333};
        applyStimulus(4'b1001, d);
        pushStart = 0;
        waitCycles(6);
        checkDrained();

        // Backpressure on output 0.
        clearCounters();
        iReady = 4'b1110;
        for (int k = 0; k < 6; k++) ph[k] = {2'b00, 4'hB, 12'(12'h500 + k)};
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            inputs[0] = ph[acc < 6 ? acc : 5];
            valid[0]  = (acc < 6);
            @(negedge clock);
            if (valid[0] && oReady[0]) acc++;
            waitCycles(1);
        end
        valid = '0;
        checkOutput("bpAccepted", 32'(acc), 32'd5);
        checkOutput("bpReady", 32'(oReady[0]), 32'd0);
        checkOutput("bpValid", 32'(oValid[0]), 32'd1);
        checkOutput("bpHold", 32'(outputs[0]), 32'(hopModel(ph[0])));
        iReady = 4'b1111;
        for (int c = 0; c < 10 && acc < 6; c++) begin
            inputs[0] = ph[5];
            valid[0]  = 1'b1;
            @(negedge clock);
            if (oReady[0]) acc++;
            waitCycles(1);
        end
        valid = '0;
        waitCycles(10);
        checkOutput("bpTotal", 32'(delivered[0]), 32'd6);
        checkDrained();

        // Parallel traffic: input i to output (i+1)%4 for 100 cycles.
        clearCounters();
        stalls = 0;
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < 4; i++) d[i] = {2'((i + 1) % 4), 4'h5, 12'(k * 4 + i)};
            valid  = 4'b1111;
            inputs = d;
            @(negedge clock);
            if (oReady != 4'b1111) stalls++;
            waitCycles(1);
        end
        valid = '0;
        waitCycles(6);
        checkOutput("parStalls", 32'(stalls), 32'd0);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("parCnt%0d", j), 32'(delivered[j]), 32'd100);
            checkOutput($sformatf("parSpan%0d", j), 32'(lastCyc[j] - firstCyc[j]), 32'd99);
        end
        checkDrained();

        // Reset in the middle of traffic.
        iReady = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            d = '0;
            d[0] = {2'b10, 4'h3, 12'(12'hC00 + k)};
            applyStimulus(4'b0001, d);
        end
        checkOutput("preRstValid", 32'(oValid[2]), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midRstValid", 32'(oValid), 32'd0);
        checkOutput("midRstData", 32'(|outputs), 32'd0);
        checkOutput("midRstReady", 32'(oReady), 32'd0);
        for (int j = 0; j < 4; j++) expQ[j].delete();
        waitCycles(2);
        reset = 1'b0;
        #1;
        checkOutput("postRstReady0", 32'(oReady), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("postRstReady1", 32'(oReady), 32'hF);
        #1;
        iReady = 4'b1111;
        clearCounters();
        waitCycles(10);
        checkOutput("postRstCnt", 32'(delivered[2]), 32'd0);
        checkOutput("spurious", 32'(spurious), 32'd0);
        checkDrained();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
